router_pkt_rx: RTL and testbench

Downstream packet receiver for the 1x1 router output port: it consumes the dut_outp/outp_valid byte stream and checks each packet for length and CRC errors. It keeps per-packet status and saturating statistics counters, readable and controllable over the same wr/rd/addr/wdata/rdata CSR bus the router uses. It sits at the router egress, both in the system and as a synthesizable scoreboard peer in the UVM environment.

---
 rtl/router_pkt_rx.sv | 205 ++++++++++++++++++++
 tb/tb_router_pkt_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_rx.sv
// Egress packet receiver: parses DA/SA/LEN/payload/CRC, counts good packets and length/CRC/truncation errors.
// Latency: pkt_done/error one cycle after the deciding byte; rdata one cycle after rd.
// Backpressure: none, one byte per cycle is always accepted; bytes arriving while disabled are drained.
module router_pkt_rx #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned MIN_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dut_outp,
    input  logic        outp_valid,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        pkt_done,
    output logic        error
);
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);
    localparam logic [7:0] MIN_L = 8'(MIN_LEN);

    typedef enum logic [2:0] {ST_IDLE, ST_SA, ST_LEN, ST_BODY, ST_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  da_q, da_d, sa_q, sa_d, len_q, len_d, crc_q, crc_d, rem_q, rem_d;
    logic        pkt_done_q, pkt_done_d, error_q, error_d;
    logic        inc_good, inc_crc, inc_len, inc_trunc;
    logic        en_q, ctrl_wr, clr;
    logic [31:0] good_q, crc_err_q, len_err_q, trunc_err_q, byte_q, last_hdr_q;
    logic [31:0] rdata_q, rdata_d;
    logic        wdata_unused;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [7:0] n);
        logic [32:0] s;
        s = {1'b0, v} + {25'b0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        da_d       = da_q;
        sa_d       = sa_q;
        len_d      = len_q;
        crc_d      = crc_q;
        rem_d      = rem_q;
        pkt_done_d = 1'b0;
        error_d    = 1'b0;
        inc_good   = 1'b0;
        inc_crc    = 1'b0;
        inc_len    = 1'b0;
        inc_trunc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (outp_valid) begin
                    if (en_q) begin
                        da_d    = dut_outp;
                        crc_d   = dut_outp;
                        state_d = ST_SA;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_SA: begin
                if (outp_valid) begin
                    sa_d    = dut_outp;
                    crc_d   = crc_q ^ dut_outp;
                    state_d = ST_LEN;
                end else begin
                    error_d   = 1'b1;
                    inc_trunc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (outp_valid) begin
                    len_d = dut_outp;
                    crc_d = crc_q ^ dut_outp;
                    if (dut_outp < MIN_L || dut_outp > MAX_L) begin
                        error_d = 1'b1;
                        inc_len = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        rem_d   = dut_outp - 8'd3;
                        state_d = ST_BODY;
                    end
                end else begin
                    error_d   = 1'b1;
                    inc_trunc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (outp_valid) begin
                    // rem_q==1 marks the trailing CRC byte
                    if (rem_q == 8'd1) begin
                        if (dut_outp == crc_q) begin
                            pkt_done_d = 1'b1;
                            inc_good   = 1'b1;
                        end else begin
                            error_d = 1'b1;
                            inc_crc = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        crc_d = crc_q ^ dut_outp;
                        rem_d = rem_q - 8'd1;
                    end
                end else begin
                    error_d   = 1'b1;
                    inc_trunc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!outp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            da_q       <= '0;
            sa_q       <= '0;
            len_q      <= '0;
            crc_q      <= '0;
            rem_q      <= '0;
            pkt_done_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            da_q       <= da_d;
            sa_q       <= sa_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            rem_q      <= rem_d;
            pkt_done_q <= pkt_done_d;
            error_q    <= error_d;
        end
    end

    assign ctrl_wr      = wr && (addr == 8'h00);
    assign clr          = ctrl_wr && wdata[1];
    assign wdata_unused = ^wdata[31:2];

    // clr has priority over any increment landing in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q        <= 1'b1;
            good_q      <= '0;
            crc_err_q   <= '0;
            len_err_q   <= '0;
            trunc_err_q <= '0;
            byte_q      <= '0;
            last_hdr_q  <= '0;
        end else begin
            if (ctrl_wr) en_q <= wdata[0];
            if (clr) begin
                good_q      <= '0;
                crc_err_q   <= '0;
                len_err_q   <= '0;
                trunc_err_q <= '0;
                byte_q      <= '0;
                last_hdr_q  <= '0;
            end else begin
                if (inc_good) begin
                    good_q     <= sat_add(good_q, 8'd1);
                    byte_q     <= sat_add(byte_q, len_q);
                    last_hdr_q <= {8'h00, len_q, sa_q, da_q};
                end
                if (inc_crc)   crc_err_q   <= sat_add(crc_err_q, 8'd1);
                if (inc_len)   len_err_q   <= sat_add(len_err_q, 8'd1);
                if (inc_trunc) trunc_err_q <= sat_add(trunc_err_q, 8'd1);
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (addr)
            8'h00:   rdata_d = {31'b0, en_q};
            8'h04:   rdata_d = good_q;
            8'h08:   rdata_d = crc_err_q;
            8'h0C:   rdata_d = len_err_q;
            8'h10:   rdata_d = trunc_err_q;
            8'h14:   rdata_d = byte_q;
            8'h18:   rdata_d = last_hdr_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata_q <= '0;
        else if (rd) rdata_q <= rdata_d;
    end

    assign rdata    = rdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_done = pkt_done_q;
    assign error    = error_q;
endmodule

// File: tb/tb_router_pkt_rx.sv
// Bench for router_pkt_rx: directed packets plus random packet mix against a packet-level model.
`timescale 1ns/1ps
module tb_router_pkt_rx;
    localparam int MAX_LEN = 64;
    localparam int MIN_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dut_outp;
    logic        outp_valid;
    logic        wr, rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy, pkt_done, error;

    always #5 clk = ~clk;

    router_pkt_rx #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk(clk), .reset(reset), .dut_outp(dut_outp), .outp_valid(outp_valid),
        .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .pkt_done(pkt_done), .error(error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // packet-level reference model
    logic [31:0] m_good = 0, m_crc = 0, m_len = 0, m_trunc = 0, m_bytes = 0, m_hdr = 0;
    int exp_done = 0, exp_err = 0;
    int n_done = 0, n_err = 0, n_both = 0;

    always @(negedge clk) begin
        if (pkt_done) n_done++;
        if (error) n_err++;
        if (pkt_done && error) n_both++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic m_ok(input int len, input logic [7:0] sa, input logic [7:0] da);
        m_good++;
        m_bytes += 32'(len);
        m_hdr = {8'h00, 8'(len), sa, da};
        exp_done++;
    endtask
    task automatic m_crcerr();   m_crc++;   exp_err++; endtask
    task automatic m_lenerr();   m_len++;   exp_err++; endtask
    task automatic m_truncerr(); m_trunc++; exp_err++; endtask
    task automatic m_clr();
        m_good = 0; m_crc = 0; m_len = 0; m_trunc = 0; m_bytes = 0; m_hdr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dut_outp   = b;
        outp_valid = 1'b1;
    endtask

    // bytes packed MSB-first: the first byte sent is the top byte of the n-byte field
    task automatic send_seq(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic go_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            outp_valid = 1'b0;
            dut_outp   = 8'h00;
        end
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic chk_csr(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        csr_read(a, v);
        chk_eq(tag, v, exp);
    endtask

    task automatic chk_all(input string tag);
        chk_csr({tag, ".good"},  8'h04, m_good);
        chk_csr({tag, ".crc"},   8'h08, m_crc);
        chk_csr({tag, ".len"},   8'h0C, m_len);
        chk_csr({tag, ".trunc"}, 8'h10, m_trunc);
        chk_csr({tag, ".bytes"}, 8'h14, m_bytes);
        chk_csr({tag, ".hdr"},   8'h18, m_hdr);
    endtask

    task automatic rand_pkt(output bit ok_b2b);
        int kind, len, cut, ntrail;
        logic [7:0] da, sa, crc;
        logic [7:0] pkt[$];
        kind = int'($urandom_range(0, 3));
        da = 8'($urandom);
        sa = 8'($urandom);
        if (kind == 2)
            len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, MIN_LEN-1))
                                              : int'($urandom_range(MAX_LEN+1, 255));
        else
            len = int'($urandom_range(MIN_LEN, MAX_LEN));
        pkt.push_back(da);
        pkt.push_back(sa);
        pkt.push_back(8'(len));
        ok_b2b = 1'b0;
        if (kind == 2) begin
            ntrail = int'($urandom_range(0, 3));
            repeat (ntrail) pkt.push_back(8'($urandom));
            foreach (pkt[i]) send_byte(pkt[i]);
            go_idle(1);
            m_lenerr();
        end else begin
            for (int i = 0; i < len - 4; i++) pkt.push_back(8'($urandom));
            crc = 8'h00;
            foreach (pkt[i]) crc ^= pkt[i];
            if (kind == 1) crc ^= 8'($urandom_range(1, 255));
            pkt.push_back(crc);
            if (kind == 3) begin
                cut = int'($urandom_range(1, len - 1));
                for (int i = 0; i < cut; i++) send_byte(pkt[i]);
                go_idle(1);
                m_truncerr();
            end else begin
                foreach (pkt[i]) send_byte(pkt[i]);
                ok_b2b = 1'b1;
                if (kind == 0) m_ok(len, sa, da);
                else m_crcerr();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        dut_outp = 8'h00; outp_valid = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = 8'h00; wdata = 32'h0; reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst.rdata", rdata, 32'h0);
        chk_eq("rst.busy", {31'b0, busy}, 32'h0);
        chk_eq("rst.pkt_done", {31'b0, pkt_done}, 32'h0);
        chk_eq("rst.error", {31'b0, error}, 32'h0);
        reset = 1'b1;
        chk_csr("rst.ctrl", 8'h00, 32'h1);
        chk_all("rst");

        // good packet
        send_seq(64'h01_02_05_AA_AC, 5);
        chk_eq("good.early", {31'b0, pkt_done}, 32'h0);
        go_idle(1);
        chk_eq("good.pulse", {31'b0, pkt_done}, 32'h1);
        chk_eq("good.noerr", {31'b0, error}, 32'h0);
        m_ok(5, 8'h02, 8'h01);
        go_idle(1);
        chk_eq("good.pulse_end", {31'b0, pkt_done}, 32'h0);
        chk_csr("good.hdr_const", 8'h18, 32'h0005_0201);
        chk_all("good");

        // CRC error
        send_seq(64'h01_02_05_AA_00, 5);
        go_idle(1);
        chk_eq("crc.pulse", {31'b0, error}, 32'h1);
        chk_eq("crc.nodone", {31'b0, pkt_done}, 32'h0);
        m_crcerr();
        chk_all("crc");

        // length errors: short length with trailing bytes, then LEN above MAX_LEN
        send_seq(64'h01_02_03, 3);
        send_byte(8'h55);
        chk_eq("len.pulse", {31'b0, error}, 32'h1);
        chk_eq("len.busy0", {31'b0, busy}, 32'h1);
        send_byte(8'h66);
        chk_eq("len.busy1", {31'b0, busy}, 32'h1);
        go_idle(1);
        chk_eq("len.busy2", {31'b0, busy}, 32'h1);
        go_idle(1);
        chk_eq("len.idle", {31'b0, busy}, 32'h0);
        m_lenerr();
        send_seq(64'h01_02_41, 3);
        go_idle(1);
        chk_eq("len65.pulse", {31'b0, error}, 32'h1);
        go_idle(1);
        m_lenerr();
        chk_all("len");

        // truncation followed by a good packet
        send_seq(64'h01_02_06_AA, 4);
        go_idle(1);
        chk_eq("trunc.early", {31'b0, error}, 32'h0);
        go_idle(1);
        chk_eq("trunc.pulse", {31'b0, error}, 32'h1);
        chk_eq("trunc.idle", {31'b0, busy}, 32'h0);
        m_truncerr();
        send_seq(64'h03_04_04_03, 4);
        go_idle(1);
        chk_eq("trunc.next_ok", {31'b0, pkt_done}, 32'h1);
        m_ok(4, 8'h04, 8'h03);
        chk_all("trunc");

        // back-to-back after clearing the counters
        csr_write(8'h00, 32'h3);
        m_clr();
        send_seq(64'h01_02_05_AA_AC, 5);
        send_byte(8'h03);
        chk_eq("b2b.pulse1", {31'b0, pkt_done}, 32'h1);
        m_ok(5, 8'h02, 8'h01);
        send_seq(64'h04_04_03, 3);
        go_idle(1);
        chk_eq("b2b.pulse2", {31'b0, pkt_done}, 32'h1);
        m_ok(4, 8'h04, 8'h03);
        chk_csr("b2b.bytes_const", 8'h14, 32'd9);
        chk_all("b2b");

        // RO and unmapped addresses
        csr_write(8'h04, 32'h0000_FFFF);
        chk_csr("ro.good", 8'h04, m_good);
        chk_csr("unmapped", 8'h1C, 32'h0);
        chk_csr("ctrl.en", 8'h00, 32'h1);

        // clearing en mid-packet finishes that packet, then blocks the next
        send_seq(64'h01_02_05, 3);
        @(negedge clk);
        dut_outp = 8'hAA; outp_valid = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 32'h0;
        send_byte(8'hAC);
        wr = 1'b0;
        go_idle(1);
        chk_eq("en.midpkt", {31'b0, pkt_done}, 32'h1);
        m_ok(5, 8'h02, 8'h01);
        chk_csr("en.ctrl0", 8'h00, 32'h0);
        send_seq(64'h01_02_05_AA_AC, 5);
        chk_eq("en.drain_busy", {31'b0, busy}, 32'h1);
        go_idle(2);
        chk_eq("en.drain_idle", {31'b0, busy}, 32'h0);
        chk_all("en_off");
        csr_write(8'h00, 32'h1);

        // clr in the same cycle as the final CRC byte
        send_seq(64'h01_02_05_AA, 4);
        @(negedge clk);
        dut_outp = 8'hAC; outp_valid = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 32'h3;
        @(negedge clk);
        chk_eq("clr.pulse", {31'b0, pkt_done}, 32'h1);
        wr = 1'b0; outp_valid = 1'b0;
        exp_done++;
        m_clr();
        chk_all("clr");

        // random packet mix, optionally back-to-back
        for (int i = 0; i < 40; i++) begin
            rand_pkt(ok);
            if (!ok || $urandom_range(0, 1) == 1) go_idle(int'($urandom_range(1, 2)));
        end
        go_idle(2);
        chk_all("rand");
        chk_eq("pulse.done_total", n_done, exp_done);
        chk_eq("pulse.err_total", n_err, exp_err);
        chk_eq("pulse.both", n_both, 32'h0);

        // reset in the middle of BODY, with en cleared
        send_seq(64'h01_02_08_11, 4);
        csr_write(8'h00, 32'h0);
        chk_eq("rstmid.busy", {31'b0, busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk_eq("rstmid.busy0", {31'b0, busy}, 32'h0);
        chk_eq("rstmid.done0", {31'b0, pkt_done}, 32'h0);
        chk_eq("rstmid.err0", {31'b0, error}, 32'h0);
        chk_eq("rstmid.rdata0", rdata, 32'h0);
        outp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_csr("rstmid.ctrl", 8'h00, 32'h1);
        m_clr();
        chk_all("rstmid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
